plru16_alloc_ctrl: RTL

Victim-allocation controller for a 16-way set-associative cache. Holds one 15-bit tree-PLRU state word per set and serves two requesters. A fire-and-forget hit-touch port updates recency. A valid/ready allocation port returns a victim way, preferring invalid ways, and commits that victim as most-recently-used when the response is accepted. Sits beside the tag array in the L1/L2 miss path, between the hit/miss detector and the refill engine.

---
 rtl/plru16_pkg.sv | 55 +++++
 rtl/plru16_alloc_ctrl_state_ram.sv | 42 ++++
 rtl/plru16_alloc_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/plru16_pkg.sv
// Shared constants, FSM state type and tree-PLRU helpers for the 16-way allocation controller.
package plru16_pkg;

    localparam int unsigned PLRU16_NODES = 15;
    localparam int unsigned PLRU16_WAYS  = 16;

    typedef enum logic {IDLE, RESP} plru16_state_e;

    // Heap-ordered walk: the path bits from root to leaf spell the way index MSB first.
    function automatic logic [3:0] plru16_victim(input logic [PLRU16_NODES-1:0] state);
        logic [3:0] node;
        logic [3:0] way;
        logic       b;
        node = 4'd0;
        way  = 4'd0;
        for (int d = 0; d < 4; d++) begin
            b    = state[node];
            way  = {way[2:0], b};
            node = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
        end
        return way;
    endfunction

    function automatic logic [PLRU16_NODES-1:0] plru16_touch(input logic [PLRU16_NODES-1:0] state,
                                                             input logic [3:0] way);
        logic [PLRU16_NODES-1:0] s;
        logic [3:0]              node;
        logic [3:0]              w;
        logic                    b;
        s    = state;
        node = 4'd0;
        w    = way;
        for (int d = 0; d < 4; d++) begin
            b       = w[3];
            s[node] = ~b;
            node    = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
            w       = w << 1;
        end
        return s;
    endfunction

    function automatic logic [3:0] lowest_set16(input logic [PLRU16_WAYS-1:0] mask);
        logic [PLRU16_WAYS-1:0] m;
        logic [3:0]             way;
        m   = mask;
        way = 4'd0;
        // Scan high to low so the last hit recorded is the lowest set bit.
        for (int i = 0; i < 16; i++) begin
            if (m[15]) way = 4'(15 - i);
            m = m << 1;
        end
        return way;
    endfunction

endpackage

// File: rtl/plru16_alloc_ctrl_state_ram.sv
// Per-set PLRU state words: one combinational read port, hit and commit write ports.
module plru16_alloc_ctrl_state_ram
    import plru16_pkg::*;
#(
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned SET_W    = $clog2(NUM_SETS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SET_W-1:0]        rd_set,
    output logic [PLRU16_NODES-1:0] rd_state,
    input  logic                    hit_valid,
    input  logic [SET_W-1:0]        hit_set,
    input  logic [3:0]              hit_way,
    input  logic                    cm_valid,
    input  logic [SET_W-1:0]        cm_set,
    input  logic [3:0]              cm_way
);

    logic [PLRU16_NODES-1:0] mem_q [NUM_SETS];
    logic [PLRU16_NODES-1:0] mem_d [NUM_SETS];

    assign rd_state = mem_q[rd_set];

    // Hit is applied before commit so a same-set collision leaves the victim MRU.
    always_comb begin
        for (int i = 0; i < NUM_SETS; i++) begin
            mem_d[i] = mem_q[i];
            if (hit_valid && hit_set == SET_W'(i)) mem_d[i] = plru16_touch(mem_d[i], hit_way);
            if (cm_valid && cm_set == SET_W'(i))   mem_d[i] = plru16_touch(mem_d[i], cm_way);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/plru16_alloc_ctrl.sv
// Victim-allocation controller: hit-touch port plus valid/ready allocation handshake.
module plru16_alloc_ctrl
    import plru16_pkg::*;
#(
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_valid,
    input  logic [SET_W-1:0] hit_set,
    input  logic [3:0]       hit_way,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic [15:0]      req_inv_mask,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [3:0]       resp_way,
    output logic             resp_from_inv
);

    plru16_state_e           state_q, state_d;
    logic [SET_W-1:0]        set_q, set_d;
    logic [3:0]              way_q, way_d;
    logic                    inv_q, inv_d;
    logic [PLRU16_NODES-1:0] rd_state;
    logic [3:0]              victim;
    logic                    victim_inv;
    logic                    commit;

    plru16_alloc_ctrl_state_ram #(
        .NUM_SETS (NUM_SETS),
        .SET_W    (SET_W)
    ) u_state_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_set    (req_set),
        .rd_state  (rd_state),
        .hit_valid (hit_valid),
        .hit_set   (hit_set),
        .hit_way   (hit_way),
        .cm_valid  (commit),
        .cm_set    (set_q),
        .cm_way    (way_q)
    );

    always_comb begin
        victim_inv = |req_inv_mask;
        victim     = victim_inv ? lowest_set16(req_inv_mask) : plru16_victim(rd_state);
        commit     = (state_q == RESP) && resp_ready;

        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        inv_d   = inv_q;
        if (state_q == IDLE) begin
            if (req_valid) begin
                state_d = RESP;
                set_d   = req_set;
                way_d   = victim;
                inv_d   = victim_inv;
            end
        end else if (resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= 4'd0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            inv_q   <= inv_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_way      = way_q;
    assign resp_from_inv = inv_q;

endmodule
